// File: rtl/fpga_piano.sv
// fpga_piano: eight-key piano top level.
//
// Modes: FREE (switches play directly), AUTO_ODE and AUTO_DOREMI (autoplay
// a stored song), LEARN (LEDs show the next Do-Re-Mi note, the display
// counts correct presses and mistakes), DONE (learn sequence finished).
//
// Ports:
//   CLK              system clock, everything on the rising edge
//   RESET            synchronous active-high reset
//   ODE_TO_JOY_AUTO  button, enters AUTO_ODE
//   DOREMI_AUTO      button, enters AUTO_DOREMI
//   DOREMI_LEARN     button, enters LEARN
//   sw[7:0]          note keys, sw[7]=C4 ... sw[0]=C5
//   FREQ             square-wave tone, 0 when silent
//   Led[7:0]         note indicator, bit i pairs with sw[i]
//   seg[7:0]         active-low segments {dp,g,f,e,d,c,b,a}
//   an[3:0]          active-low digit enables, an[3] leftmost
//
// Build option: define DEBOUNCE_EN to insert a per-input debouncer after the
// synchronizer; without it the synchronized inputs are used directly.

module fpga_piano #(
    parameter int unsigned CLK_HZ          = 100000000,
    parameter int unsigned NOTE_TICKS      = 25000000,
    parameter int unsigned REST_TICKS      = 5000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REFRESH_CYCLES  = 100000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ODE_TO_JOY_AUTO,
    input  logic       DOREMI_AUTO,
    input  logic       DOREMI_LEARN,
    input  logic [7:0] sw,
    output logic       FREQ,
    output logic [7:0] Led,
    output logic [7:0] seg,
    output logic [3:0] an
);

    typedef enum logic [2:0] {
        MODE_FREE,
        MODE_ODE,
        MODE_DOREMI,
        MODE_LEARN,
        MODE_DONE
    } mode_t;

    localparam logic [31:0] HALF_C4 = 32'(CLK_HZ / (2 * 262));
    localparam logic [31:0] HALF_D4 = 32'(CLK_HZ / (2 * 294));
    localparam logic [31:0] HALF_E4 = 32'(CLK_HZ / (2 * 330));
    localparam logic [31:0] HALF_F4 = 32'(CLK_HZ / (2 * 349));
    localparam logic [31:0] HALF_G4 = 32'(CLK_HZ / (2 * 392));
    localparam logic [31:0] HALF_A4 = 32'(CLK_HZ / (2 * 440));
    localparam logic [31:0] HALF_B4 = 32'(CLK_HZ / (2 * 494));
    localparam logic [31:0] HALF_C5 = 32'(CLK_HZ / (2 * 523));

    // Note codes: 0 rest, 1..8 = C4 D4 E4 F4 G4 A4 B4 C5.
    function automatic logic [3:0] odeNote(input logic [5:0] idx);
        logic [3:0] n;
        n = 4'd0;
        case (idx)
            6'd0:  n = 4'd3; 6'd1:  n = 4'd3; 6'd2:  n = 4'd4; 6'd3:  n = 4'd5; 6'd4:  n = 4'd5;
            6'd5:  n = 4'd4; 6'd6:  n = 4'd3; 6'd7:  n = 4'd2; 6'd8:  n = 4'd1; 6'd9:  n = 4'd1;
            6'd10: n = 4'd2; 6'd11: n = 4'd3; 6'd12: n = 4'd3; 6'd13: n = 4'd2; 6'd14: n = 4'd2;
            6'd15: n = 4'd3; 6'd16: n = 4'd3; 6'd17: n = 4'd4; 6'd18: n = 4'd5; 6'd19: n = 4'd5;
            6'd20: n = 4'd4; 6'd21: n = 4'd3; 6'd22: n = 4'd2; 6'd23: n = 4'd1; 6'd24: n = 4'd1;
            6'd25: n = 4'd2; 6'd26: n = 4'd3; 6'd27: n = 4'd2; 6'd28: n = 4'd1; 6'd29: n = 4'd1;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    function automatic logic [3:0] doremiNote(input logic [5:0] idx);
        logic [3:0] n;
        n = 4'd0;
        case (idx)
            6'd0:  n = 4'd1; 6'd1:  n = 4'd2; 6'd2:  n = 4'd3; 6'd3:  n = 4'd1; 6'd4:  n = 4'd3; 6'd5:  n = 4'd1; 6'd6:  n = 4'd3;
            6'd7:  n = 4'd2; 6'd8:  n = 4'd3; 6'd9:  n = 4'd4; 6'd10: n = 4'd4; 6'd11: n = 4'd3; 6'd12: n = 4'd2; 6'd13: n = 4'd4;
            6'd14: n = 4'd3; 6'd15: n = 4'd4; 6'd16: n = 4'd5; 6'd17: n = 4'd3; 6'd18: n = 4'd5; 6'd19: n = 4'd3; 6'd20: n = 4'd5;
            6'd21: n = 4'd4; 6'd22: n = 4'd5; 6'd23: n = 4'd6; 6'd24: n = 4'd6; 6'd25: n = 4'd5; 6'd26: n = 4'd4; 6'd27: n = 4'd6;
            6'd28: n = 4'd5; 6'd29: n = 4'd1; 6'd30: n = 4'd2; 6'd31: n = 4'd3; 6'd32: n = 4'd4; 6'd33: n = 4'd5; 6'd34: n = 4'd6;
            6'd35: n = 4'd6; 6'd36: n = 4'd2; 6'd37: n = 4'd3; 6'd38: n = 4'd4; 6'd39: n = 4'd5; 6'd40: n = 4'd6; 6'd41: n = 4'd7;
            6'd42: n = 4'd7; 6'd43: n = 4'd3; 6'd44: n = 4'd4; 6'd45: n = 4'd5; 6'd46: n = 4'd6; 6'd47: n = 4'd7; 6'd48: n = 4'd8;
            6'd49: n = 4'd8; 6'd50: n = 4'd7; 6'd51: n = 4'd6; 6'd52: n = 4'd4; 6'd53: n = 4'd7; 6'd54: n = 4'd5; 6'd55: n = 4'd8;
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    // The highest set switch index is the lowest pitch; it wins.
    function automatic logic [3:0] lowestKey(input logic [7:0] keys);
        logic [3:0] code;
        code = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (keys[i]) code = 4'(8 - i);
        end
        return code;
    endfunction

    function automatic logic [7:0] noteToLed(input logic [3:0] code);
        logic [7:0] led;
        case (code)
            4'd1:    led = 8'h80;
            4'd2:    led = 8'h40;
            4'd3:    led = 8'h20;
            4'd4:    led = 8'h10;
            4'd5:    led = 8'h08;
            4'd6:    led = 8'h04;
            4'd7:    led = 8'h02;
            4'd8:    led = 8'h01;
            default: led = 8'h00;
        endcase
        return led;
    endfunction

    function automatic logic [7:0] letterSeg(input logic [3:0] code);
        logic [7:0] s;
        case (code)
            4'd1, 4'd8: s = 8'hC6;
            4'd2:       s = 8'hA1;
            4'd3:       s = 8'h86;
            4'd4:       s = 8'h8E;
            4'd5:       s = 8'hC2;
            4'd6:       s = 8'h88;
            4'd7:       s = 8'h83;
            default:    s = 8'hFF;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] digitSeg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Input bundle: [10]=ODE, [9]=DOREMI_AUTO, [8]=LEARN, [7:0]=sw.
    logic [10:0] r_sync1;
    logic [10:0] r_sync2;
    logic [10:0] w_deb;
    logic [10:0] r_debPrev;
    logic [10:0] w_rise;

    // Two-flop synchronizer for all asynchronous inputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {ODE_TO_JOY_AUTO, DOREMI_AUTO, DOREMI_LEARN, sw};
            r_sync2 <= r_sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [10:0]     r_stable;
    logic [DB_W-1:0] r_dbCnt [11];

    // A bit follows its synchronized input only after the input has differed
    // from the accepted value for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stable <= '0;
            for (int i = 0; i < 11; i++) r_dbCnt[i] <= '0;
        end else begin
            for (int i = 0; i < 11; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable[i] <= r_sync2[i];
                    r_dbCnt[i]  <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_deb = r_stable;
`else
    assign w_deb = r_sync2;
`endif

    // Previous debounced value for rising-edge detection.
    always_ff @(posedge CLK) begin
        if (RESET) r_debPrev <= '0;
        else       r_debPrev <= w_deb;
    end

    assign w_rise = w_deb & ~r_debPrev;

    mode_t       r_mode;
    logic [5:0]  r_ptr;
    logic [31:0] r_timer;
    logic        r_inRest;
    logic [6:0]  r_correct;
    logic [6:0]  r_mistakes;
    logic [3:0]  r_note;

    logic [3:0]  w_songNote;
    logic [5:0]  w_lastIdx;
    logic [3:0]  w_expect;
    logic [3:0]  w_pressCode;
    logic [3:0]  w_heldCode;
    logic [3:0]  w_noteNext;
    logic [7:0]  w_ledNext;

    assign w_songNote  = (r_mode == MODE_ODE) ? odeNote(r_ptr) : doremiNote(r_ptr);
    assign w_lastIdx   = (r_mode == MODE_ODE) ? 6'd29 : 6'd55;
    assign w_expect    = doremiNote(r_ptr);
    assign w_pressCode = lowestKey(w_rise[7:0]);
    assign w_heldCode  = lowestKey(w_deb[7:0]);

    // Sounding note and LED pattern implied by the current mode.
    always_comb begin
        w_noteNext = 4'd0;
        w_ledNext  = 8'h00;
        case (r_mode)
            MODE_FREE: begin
                w_noteNext = w_heldCode;
                w_ledNext  = w_deb[7:0];
            end
            MODE_ODE, MODE_DOREMI: begin
                if (!r_inRest) begin
                    w_noteNext = w_songNote;
                    w_ledNext  = noteToLed(w_songNote);
                end
            end
            MODE_LEARN: begin
                w_noteNext = w_heldCode;
                w_ledNext  = noteToLed(w_expect);
            end
            MODE_DONE: w_ledNext = 8'hFF;
            default: ;
        endcase
    end

    // Mode FSM with registered note and LED outputs. A button edge always
    // wins over the per-mode activity on the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_mode     <= MODE_FREE;
            r_ptr      <= '0;
            r_timer    <= '0;
            r_inRest   <= 1'b0;
            r_correct  <= '0;
            r_mistakes <= '0;
            r_note     <= '0;
            Led        <= '0;
        end else begin
            r_note <= w_noteNext;
            Led    <= w_ledNext;
            if (|w_rise[10:8]) begin
                if (w_rise[10])     r_mode <= MODE_ODE;
                else if (w_rise[9]) r_mode <= MODE_DOREMI;
                else                r_mode <= MODE_LEARN;
                r_ptr      <= '0;
                r_timer    <= '0;
                r_inRest   <= 1'b0;
                r_correct  <= '0;
                r_mistakes <= '0;
            end else begin
                case (r_mode)
                    MODE_ODE, MODE_DOREMI: begin
                        if (!r_inRest) begin
                            if (r_timer == NOTE_TICKS - 1) begin
                                r_timer  <= '0;
                                r_inRest <= 1'b1;
                            end else begin
                                r_timer <= r_timer + 32'd1;
                            end
                        end else if (r_timer == REST_TICKS - 1) begin
                            r_timer  <= '0;
                            r_inRest <= 1'b0;
                            if (r_ptr == w_lastIdx) begin
                                r_mode <= MODE_FREE;
                                r_ptr  <= '0;
                            end else begin
                                r_ptr <= r_ptr + 6'd1;
                            end
                        end else begin
                            r_timer <= r_timer + 32'd1;
                        end
                    end
                    MODE_LEARN: begin
                        if (|w_rise[7:0]) begin
                            if (w_pressCode == w_expect) begin
                                if (r_correct != 7'd99) r_correct <= r_correct + 7'd1;
                                r_ptr <= r_ptr + 6'd1;
                                if (r_ptr == 6'd55) r_mode <= MODE_DONE;
                            end else if (r_mistakes != 7'd99) begin
                                r_mistakes <= r_mistakes + 7'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [31:0] r_toneCnt;
    logic [3:0]  r_toneNote;
    logic [31:0] w_half;

    always_comb begin
        case (r_note)
            4'd1:    w_half = HALF_C4;
            4'd2:    w_half = HALF_D4;
            4'd3:    w_half = HALF_E4;
            4'd4:    w_half = HALF_F4;
            4'd5:    w_half = HALF_G4;
            4'd6:    w_half = HALF_A4;
            4'd7:    w_half = HALF_B4;
            4'd8:    w_half = HALF_C5;
            default: w_half = 32'd0;
        endcase
    end

    // Tone generator: a note change restarts the half-period from a low level.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_toneCnt  <= '0;
            r_toneNote <= '0;
            FREQ       <= 1'b0;
        end else begin
            r_toneNote <= r_note;
            if (r_note != r_toneNote || r_note == 4'd0) begin
                r_toneCnt <= '0;
                FREQ      <= 1'b0;
            end else if ((r_toneCnt + 32'd1) >= w_half) begin
                r_toneCnt <= '0;
                FREQ      <= ~FREQ;
            end else begin
                r_toneCnt <= r_toneCnt + 32'd1;
            end
        end
    end

    logic [31:0] r_refCnt;
    logic [1:0]  r_digit;
    logic [7:0]  w_segNext;
    logic [3:0]  w_corTens, w_corOnes, w_misTens, w_misOnes;

    assign w_corTens = 4'(r_correct / 7'd10);
    assign w_corOnes = 4'(r_correct % 7'd10);
    assign w_misTens = 4'(r_mistakes / 7'd10);
    assign w_misOnes = 4'(r_mistakes % 7'd10);

    always_comb begin
        w_segNext = 8'hFF;
        case (r_mode)
            MODE_FREE: begin
                if (r_digit == 2'd0) w_segNext = letterSeg(r_note);
            end
            MODE_ODE, MODE_DOREMI: begin
                if (r_digit == 2'd3)      w_segNext = 8'h88;
                else if (r_digit == 2'd0) w_segNext = letterSeg(r_note);
            end
            MODE_LEARN, MODE_DONE: begin
                case (r_digit)
                    2'd3:    w_segNext = digitSeg(w_corTens);
                    2'd2:    w_segNext = digitSeg(w_corOnes);
                    2'd1:    w_segNext = digitSeg(w_misTens);
                    default: w_segNext = digitSeg(w_misOnes);
                endcase
            end
            default: ;
        endcase
    end

    // Display scan: an and seg are registered together so they always agree.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_refCnt <= '0;
            r_digit  <= '0;
            seg      <= 8'hFF;
            an       <= 4'hF;
        end else begin
            if (r_refCnt == REFRESH_CYCLES - 1) begin
                r_refCnt <= '0;
                r_digit  <= r_digit + 2'd1;
            end else begin
                r_refCnt <= r_refCnt + 32'd1;
            end
            an  <= ~(4'b0001 << r_digit);
            seg <= w_segNext;
        end
    end

endmodule

// File: tb/tb_fpga_piano.sv
// tb_fpga_piano: directed bench for fpga_piano with shrunk timing parameters.
// FREE-mode vectors come from a table; autoplay, learn, reset and glitch
// behaviour are exercised by hand-written sequences.

module tb_fpga_piano;

    localparam int unsigned CLK_HZ          = 100000;
    localparam int unsigned NOTE_TICKS      = 20;
    localparam int unsigned REST_TICKS      = 5;
    localparam int unsigned DEBOUNCE_CYCLES = 4;
    localparam int unsigned REFRESH_CYCLES  = 8;
    localparam int          SETTLE          = 12;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ODE_TO_JOY_AUTO;
    logic       DOREMI_AUTO;
    logic       DOREMI_LEARN;
    logic [7:0] sw;
    logic       FREQ;
    logic [7:0] Led;
    logic [7:0] seg;
    logic [3:0] an;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] keys;
        logic [7:0] expLed;
        int         expHalf;
        logic [7:0] expSeg0;
    } freeVec_t;

    freeVec_t   vecs [6];
    logic [7:0] songLed [56];
    int         songLen;

    fpga_piano #(
        .CLK_HZ         (CLK_HZ),
        .NOTE_TICKS     (NOTE_TICKS),
        .REST_TICKS     (REST_TICKS),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REFRESH_CYCLES (REFRESH_CYCLES)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .ODE_TO_JOY_AUTO(ODE_TO_JOY_AUTO),
        .DOREMI_AUTO    (DOREMI_AUTO),
        .DOREMI_LEARN   (DOREMI_LEARN),
        .sw             (sw),
        .FREQ           (FREQ),
        .Led            (Led),
        .seg            (seg),
        .an             (an)
    );

    always #5 CLK = ~CLK;

    // Hard stop in case a sequence stalls somewhere unbounded.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic applyStimulus(input logic [7:0] keys);
        sw = keys;
        tick(SETTLE);
    endtask

    task automatic pressKey(input logic [7:0] keys);
        applyStimulus(keys);
        applyStimulus(8'h00);
    endtask

    // Mask bits: [2]=ODE, [1]=DOREMI_AUTO, [0]=LEARN. Returns right after release.
    task automatic pressButton(input logic [2:0] mask);
        ODE_TO_JOY_AUTO = mask[2];
        DOREMI_AUTO     = mask[1];
        DOREMI_LEARN    = mask[0];
        tick(SETTLE);
        ODE_TO_JOY_AUTO = 1'b0;
        DOREMI_AUTO     = 1'b0;
        DOREMI_LEARN    = 1'b0;
    endtask

    task automatic waitLed(input bit wantNonZero, input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            if ((Led != 8'h00) == wantNonZero) begin
                ok = 1'b1;
                return;
            end
            tick(1);
        end
    endtask

    // Half period in cycles between two FREQ toggles; -1 if FREQ never toggles.
    task automatic measureHalf(output int half);
        logic prev;
        int   n;
        half = -1;
        prev = FREQ;
        n    = 0;
        while (FREQ == prev && n < 500) begin tick(1); n++; end
        if (FREQ == prev) return;
        prev = FREQ;
        n    = 0;
        while (FREQ == prev && n < 500) begin tick(1); n++; end
        if (FREQ != prev) half = n;
    endtask

    // Segment pattern of digit d; 8'h00 (never a legal glyph here) on timeout.
    task automatic readDigit(input int d, output logic [7:0] s);
        logic [3:0] want;
        want = ~(4'b0001 << d);
        s    = 8'h00;
        for (int n = 0; n < 4 * int'(REFRESH_CYCLES) + 8; n++) begin
            if (an == want) begin
                s = seg;
                return;
            end
            tick(1);
        end
    endtask

    function automatic logic [7:0] letterLed(input byte c);
        case (c)
            "C":     return 8'h80;
            "D":     return 8'h40;
            "E":     return 8'h20;
            "F":     return 8'h10;
            "G":     return 8'h08;
            "A":     return 8'h04;
            "B":     return 8'h02;
            "H":     return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    task automatic loadSong(input string notes);
        songLen = notes.len();
        for (int i = 0; i < songLen; i++) songLed[i] = letterLed(notes[i]);
    endtask

    task automatic checkSong(input string name);
        bit ok;
        for (int i = 0; i < songLen; i++) begin
            waitLed(1'b1, int'(REST_TICKS) + 6, ok);
            checkOutput($sformatf("%s note %0d start", name, i), 32'(ok), 32'd1);
            if (!ok) return;
            checkOutput($sformatf("%s note %0d led", name, i), 32'(Led), 32'(songLed[i]));
            waitLed(1'b0, int'(NOTE_TICKS) + 6, ok);
            checkOutput($sformatf("%s note %0d end", name, i), 32'(ok), 32'd1);
            if (!ok) return;
        end
    endtask

    initial begin
        logic [7:0] s;
        int         h;
        bit         ok;
        string      doremiStr;

        doremiStr = {"CDECECE", "DEFFEDF", "EFGEGEG", "FGAAGFA",
                     "GCDEFGA", "ADEFGAB", "BEFGABH", "HBAFBGH"};

        vecs[0] = '{keys: 8'h20, expLed: 8'h20, expHalf: 151, expSeg0: 8'h86};
        vecs[1] = '{keys: 8'hA0, expLed: 8'hA0, expHalf: 190, expSeg0: 8'hC6};
        vecs[2] = '{keys: 8'h01, expLed: 8'h01, expHalf: 95,  expSeg0: 8'hC6};
        vecs[3] = '{keys: 8'h0C, expLed: 8'h0C, expHalf: 127, expSeg0: 8'hC2};
        vecs[4] = '{keys: 8'h48, expLed: 8'h48, expHalf: 170, expSeg0: 8'hA1};
        vecs[5] = '{keys: 8'h00, expLed: 8'h00, expHalf: -1,  expSeg0: 8'hFF};

        RESET           = 1'b1;
        ODE_TO_JOY_AUTO = 1'b0;
        DOREMI_AUTO     = 1'b0;
        DOREMI_LEARN    = 1'b0;
        sw              = 8'h00;
        tick(3);
        checkOutput("reset FREQ", 32'(FREQ), 32'd0);
        checkOutput("reset Led", 32'(Led), 32'h00);
        checkOutput("reset seg", 32'(seg), 32'hFF);
        checkOutput("reset an", 32'(an), 32'hF);
        RESET = 1'b0;
        tick(2);

        // FREE mode table.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].keys);
            checkOutput($sformatf("free[%0d] Led", i), 32'(Led), 32'(vecs[i].expLed));
            measureHalf(h);
            checkOutput($sformatf("free[%0d] half", i), 32'(h), 32'(vecs[i].expHalf));
            readDigit(0, s);
            checkOutput($sformatf("free[%0d] digit0", i), 32'(s), 32'(vecs[i].expSeg0));
            readDigit(3, s);
            checkOutput($sformatf("free[%0d] digit3", i), 32'(s), 32'hFF);
        end

        // Ode to Joy autoplay; switches are set but must be ignored until the end.
        $display("[TB] autoplay ode");
        pressButton(3'b100);
        sw = 8'h10;
        loadSong("EEFGGFEDCCDEEDDEEFGGFEDCCDEDCC");
        checkSong("ode");
        tick(int'(REST_TICKS) + 4);
        checkOutput("ode back to free Led", 32'(Led), 32'h10);
        readDigit(3, s);
        checkOutput("ode back to free digit3", 32'(s), 32'hFF);
        readDigit(0, s);
        checkOutput("ode back to free digit0", 32'(s), 32'h8E);
        applyStimulus(8'h00);

        // Do-Re-Mi autoplay.
        $display("[TB] autoplay doremi");
        pressButton(3'b010);
        loadSong(doremiStr);
        checkSong("doremi");
        tick(int'(REST_TICKS) + 4);
        checkOutput("doremi back to free Led", 32'(Led), 32'h00);

        // Same-cycle ODE and DOREMI: ODE wins, first note is E.
        pressButton(3'b110);
        waitLed(1'b1, int'(REST_TICKS) + 6, ok);
        checkOutput("priority start", 32'(ok), 32'd1);
        checkOutput("priority first note", 32'(Led), 32'h20);
        readDigit(3, s);
        checkOutput("auto digit3", 32'(s), 32'h88);

        // Reset in the middle of the song.
        waitLed(1'b1, int'(NOTE_TICKS) + int'(REST_TICKS) + 6, ok);
        checkOutput("pre-reset note", 32'(ok), 32'd1);
        tick(3);
        RESET = 1'b1;
        tick(1);
        checkOutput("midsong reset FREQ", 32'(FREQ), 32'd0);
        checkOutput("midsong reset Led", 32'(Led), 32'h00);
        checkOutput("midsong reset an", 32'(an), 32'hF);
        checkOutput("midsong reset seg", 32'(seg), 32'hFF);
        RESET = 1'b0;
        applyStimulus(8'h02);
        checkOutput("after reset free Led", 32'(Led), 32'h02);
        tick(int'(NOTE_TICKS) + int'(REST_TICKS));
        checkOutput("after reset stays free", 32'(Led), 32'h02);
        applyStimulus(8'h00);

        // LEARN: C D E correct, D wrong, C correct.
        $display("[TB] learn");
        pressButton(3'b001);
        tick(SETTLE);
        checkOutput("learn expect C", 32'(Led), 32'h80);
        pressKey(8'h80);
        pressKey(8'h40);
        applyStimulus(8'h20);
        measureHalf(h);
        checkOutput("learn held E half", 32'(h), 32'd151);
        applyStimulus(8'h00);
        pressKey(8'h40);
        pressKey(8'h80);
        checkOutput("learn expect E", 32'(Led), 32'h20);
        readDigit(3, s); checkOutput("learn correct tens", 32'(s), 32'hC0);
        readDigit(2, s); checkOutput("learn correct ones", 32'(s), 32'h99);
        readDigit(1, s); checkOutput("learn mistakes tens", 32'(s), 32'hC0);
        readDigit(0, s); checkOutput("learn mistakes ones", 32'(s), 32'hF9);

        // Mistake counter saturates at 99.
        for (int i = 0; i < 100; i++) pressKey(8'h04);
        readDigit(1, s); checkOutput("sat mistakes tens", 32'(s), 32'h90);
        readDigit(0, s); checkOutput("sat mistakes ones", 32'(s), 32'h90);
        checkOutput("sat expect unchanged", 32'(Led), 32'h20);

        // Re-entering LEARN clears; play the whole song to reach DONE.
        pressButton(3'b001);
        tick(SETTLE);
        readDigit(0, s); checkOutput("relearn mistakes cleared", 32'(s), 32'hC0);
        for (int i = 0; i < doremiStr.len(); i++) pressKey(letterLed(doremiStr[i]));
        checkOutput("done Led", 32'(Led), 32'hFF);
        readDigit(3, s); checkOutput("done correct tens", 32'(s), 32'h92);
        readDigit(2, s); checkOutput("done correct ones", 32'(s), 32'h82);
        applyStimulus(8'h80);
        measureHalf(h);
        checkOutput("done silent", 32'(h), 32'hFFFFFFFF);
        applyStimulus(8'h00);
        checkOutput("done Led after press", 32'(Led), 32'hFF);
        readDigit(0, s); checkOutput("done press ignored", 32'(s), 32'hC0);

        // Glitch burst then a steady press of C in LEARN.
        pressButton(3'b001);
        tick(SETTLE);
        for (int i = 0; i < 3; i++) begin
            sw = 8'h80; tick(1);
            sw = 8'h00; tick(1);
        end
        pressKey(8'h80);
        checkOutput("glitch expect D", 32'(Led), 32'h40);
        readDigit(2, s); checkOutput("glitch correct ones", 32'(s), 32'hF9);
        readDigit(0, s);
`ifdef DEBOUNCE_EN
        checkOutput("glitch mistakes ones", 32'(s), 32'hC0);
`else
        checkOutput("glitch mistakes ones", 32'(s), 32'hB0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
